// File: rtl/axi_pkg.sv
// ---------------------------------------------------------------------------
// axi_pkg
// Shared definitions for the AXI read responder slice:
//   - burst and response encodings
//   - ar_req_t : one queued read request, already decoded to an SRAM word
//                address plus an error flag, so the engine never looks at
//                raw AXI fields again
//   - eng_state_t : read engine states
//   - burst_unsupported() : true for WRAP and the reserved burst encoding
// ---------------------------------------------------------------------------
package axi_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Widths used to size ar_req_t; the responder's AXI_IDW / SRAM_AW
    // parameters default to these and must be kept equal to them.
    localparam int REQ_IDW = 4;
    localparam int REQ_AW  = 12;

    // The engine reuses 'len' as its beats-left counter once a request is
    // loaded. 'fixed' selects a held word address instead of incrementing.
    typedef struct packed {
        logic [REQ_IDW-1:0] id;
        logic [REQ_AW-1:0]  word_addr;
        logic [3:0]         len;
        logic               fixed;
        logic               err;
    } ar_req_t;

    typedef enum logic {
        ST_IDLE,
        ST_RUN
    } eng_state_t;

    function automatic logic burst_unsupported(input logic [1:0] burst);
        return (burst != BURST_INCR) && (burst != BURST_FIXED);
    endfunction

endpackage

// File: rtl/axi_rd_slv_sram_if.sv
// ---------------------------------------------------------------------------
// axi_rd_slv_sram_if
// AXI3-style read address (AR) and read data (R) channels.
//   master modport : drives AR and rready, receives arready and R
//   slave  modport : receives AR and rready, drives arready and R
// Parameters: IDW (id width), DW (data width).
// ---------------------------------------------------------------------------
interface axi_rd_slv_sram_if #(
    parameter int IDW = 4,
    parameter int DW  = 256
);

    logic           arvalid;
    logic [IDW-1:0] arid;
    logic [31:0]    araddr;
    logic [3:0]     arlen;
    logic [2:0]     arsize;
    logic [1:0]     arburst;
    logic           arready;

    logic           rvalid;
    logic [IDW-1:0] rid;
    logic [DW-1:0]  rdata;
    logic [1:0]     rresp;
    logic           rlast;
    logic           rready;

    modport master (
        output arvalid, arid, araddr, arlen, arsize, arburst, rready,
        input  arready, rvalid, rid, rdata, rresp, rlast
    );

    modport slave (
        input  arvalid, arid, araddr, arlen, arsize, arburst, rready,
        output arready, rvalid, rid, rdata, rresp, rlast
    );

endinterface

// File: rtl/axi_rsp_skid_fifo.sv
// ---------------------------------------------------------------------------
// axi_rsp_skid_fifo
// Small synchronous FIFO used both as the AR request queue and as the
// 2-entry R output buffer. The head entry is presented combinationally on
// dout, and full/empty come straight from a registered count, so neither
// flag depends on the push/pop inputs of the same cycle.
// Ports:
//   clk, rst_n   clock, async active-low reset (clears storage too)
//   push, din    write strobe and data (push while full is accepted only
//                together with a pop)
//   pop, dout    read strobe and head data
//   full, empty  occupancy flags
// Parameters: WIDTH (entry width), DEPTH (entries, power of 2, >= 2).
// ---------------------------------------------------------------------------
module axi_rsp_skid_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2,
    localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW:0]      count;
    logic             do_push;
    logic             do_pop;

    // Guard the strobes so a misbehaving caller cannot corrupt the count.
    always_comb begin
        do_pop  = pop && !empty;
        do_push = push && (!full || do_pop);
    end

    // Pointers wrap naturally because DEPTH is a power of two. Storage is
    // cleared on reset so the outputs read as zero while nothing is held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    assign dout  = mem[rd_ptr];
    assign full  = (count == (PW+1)'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/axi_rd_slv_sram.sv
// ---------------------------------------------------------------------------
// axi_rd_slv_sram
// AXI3-style read responder serving AR/R transactions from a single-port
// synchronous SRAM (read data valid one cycle after the read strobe).
// Requests are queued (OUTSTD_DEPTH deep) and answered strictly in order,
// one beat per cycle with no bubble between bursts.
// Ports:
//   aclk, aresetn   clock, async active-low reset
//   axi (slave)     AR and R channels
//   o_sram_cs       SRAM read strobe
//   o_sram_addr     SRAM word address
//   i_sram_rdata    SRAM read data, one cycle after o_sram_cs
//   o_busy          queue, engine, in-flight read or output buffer active
// Parameters: AXI_IDW, AXI_DATA_WID, SRAM_AW, OUTSTD_DEPTH.
// ---------------------------------------------------------------------------
module axi_rd_slv_sram
    import axi_pkg::*;
#(
    parameter int AXI_IDW      = REQ_IDW,
    parameter int AXI_DATA_WID = 256,
    parameter int SRAM_AW      = REQ_AW,
    parameter int OUTSTD_DEPTH = 4
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    axi_rd_slv_sram_if.slave        axi,
    output logic                    o_sram_cs,
    output logic [SRAM_AW-1:0]      o_sram_addr,
    input  logic [AXI_DATA_WID-1:0] i_sram_rdata,
    output logic                    o_busy
);

    localparam int NB   = AXI_DATA_WID / 8;
    localparam int BSH  = $clog2(NB);
    localparam int OB_W = AXI_IDW + AXI_DATA_WID + 3;

    // AR queue
    ar_req_t push_req;
    ar_req_t q_head;
    logic    q_push;
    logic    q_pop;
    logic    q_full;
    logic    q_empty;

    // read engine
    eng_state_t state;
    ar_req_t    cur;
    ar_req_t    sel;
    logic       have_req;
    logic       sel_last;
    logic       issue;

    // sideband of the read currently inside the SRAM
    logic               inflight;
    logic [AXI_IDW-1:0] sb_id;
    logic               sb_last;
    logic               sb_err;

    // output buffer
    logic [OB_W-1:0] ob_din;
    logic [OB_W-1:0] ob_dout;
    logic            ob_full;
    logic            ob_empty;
    logic            r_pop;
    logic [1:0]      ob_occ;
    logic [2:0]      occ_after;
    logic            credit_ok;

    // Decode the AR beat once at push time: word address from the bits
    // above the byte lane, and an error flag for anything this memory
    // cannot honour (unsupported burst, narrow size, address beyond SRAM).
    always_comb begin
        push_req.id        = axi.arid;
        push_req.word_addr = axi.araddr[BSH+SRAM_AW-1:BSH];
        push_req.len       = axi.arlen;
        push_req.fixed     = (axi.arburst == BURST_FIXED);
        push_req.err       = burst_unsupported(axi.arburst)
                           || (axi.arsize != 3'(BSH))
                           || ((axi.araddr >> (BSH + SRAM_AW)) != 32'd0);
    end

    assign axi.arready = !q_full;
    assign q_push      = axi.arvalid && !q_full;

    axi_rsp_skid_fifo #(
        .WIDTH ($bits(ar_req_t)),
        .DEPTH (OUTSTD_DEPTH)
    ) u_ar_queue (
        .clk   (aclk),
        .rst_n (aresetn),
        .push  (q_push),
        .din   (push_req),
        .pop   (q_pop),
        .dout  (q_head),
        .full  (q_full),
        .empty (q_empty)
    );

    // Credit: the output buffer holds two beats. A read issued now lands in
    // the buffer next cycle, so count what will still be held after this
    // cycle's R handshake plus the read already in flight. Crediting the
    // pop of the current cycle is what lets a draining buffer sustain one
    // beat per cycle.
    always_comb begin
        r_pop     = axi.rvalid && axi.rready;
        ob_occ    = ob_full ? 2'd2 : (ob_empty ? 2'd0 : 2'd1);
        occ_after = {1'b0, ob_occ} + {2'b00, inflight} - {2'b00, r_pop};
        credit_ok = (occ_after < 3'd2);
    end

    // The engine issues from its loaded burst while running; when idle it
    // issues beat 0 straight from the queue head, which is what gives the
    // first SRAM read one cycle after the AR handshake. At the last beat of
    // a running burst the next head is loaded in the same cycle so the
    // following burst starts without a gap.
    always_comb begin
        sel       = (state == ST_RUN) ? cur : q_head;
        have_req  = (state == ST_RUN) || !q_empty;
        sel_last  = (sel.len == 4'd0);
        issue     = have_req && credit_ok;
        q_pop     = issue && ((state == ST_IDLE) || (sel_last && !q_empty));
    end

    assign o_sram_cs   = issue;
    assign o_sram_addr = sel.word_addr;

    // Engine state, current burst and the sideband that travels one cycle
    // behind each SRAM read.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state    <= ST_IDLE;
            cur      <= '0;
            inflight <= 1'b0;
            sb_id    <= '0;
            sb_last  <= 1'b0;
            sb_err   <= 1'b0;
        end else begin
            inflight <= issue;
            if (issue) begin
                sb_id   <= sel.id;
                sb_last <= sel_last;
                sb_err  <= sel.err;
                if (!sel_last) begin
                    cur.id        <= sel.id;
                    cur.fixed     <= sel.fixed;
                    cur.err       <= sel.err;
                    cur.len       <= sel.len - 4'd1;
                    cur.word_addr <= sel.fixed ? sel.word_addr
                                               : sel.word_addr + SRAM_AW'(1);
                    state         <= ST_RUN;
                end else if ((state == ST_RUN) && !q_empty) begin
                    cur   <= q_head;
                    state <= ST_RUN;
                end else begin
                    state <= ST_IDLE;
                end
            end
        end
    end

    // Error beats still carry the SRAM data; only the response changes.
    assign ob_din = {sb_id, i_sram_rdata, (sb_err ? RESP_SLVERR : RESP_OKAY), sb_last};

    axi_rsp_skid_fifo #(
        .WIDTH (OB_W),
        .DEPTH (2)
    ) u_out_buf (
        .clk   (aclk),
        .rst_n (aresetn),
        .push  (inflight),
        .din   (ob_din),
        .pop   (r_pop),
        .dout  (ob_dout),
        .full  (ob_full),
        .empty (ob_empty)
    );

    // R outputs come only from the buffer head, so they stay frozen while
    // the master stalls and rvalid never looks at rready.
    assign axi.rvalid = !ob_empty;
    assign axi.rid    = ob_dout[OB_W-1 -: AXI_IDW];
    assign axi.rdata  = ob_dout[AXI_DATA_WID+2:3];
    assign axi.rresp  = ob_dout[2:1];
    assign axi.rlast  = ob_dout[0];

    assign o_busy = (state == ST_RUN) || !q_empty || inflight || !ob_empty;

endmodule

// File: tb/tb_axi_rd_slv_sram.sv
// ---------------------------------------------------------------------------
// tb_axi_rd_slv_sram
// Scoreboard bench for axi_rd_slv_sram. Each accepted AR pushes its
// expected beats (computed from the memory image and the AXI rules) into a
// queue; a monitor on the falling edge pops and compares every R beat and
// checks that stalled outputs hold still.
// ---------------------------------------------------------------------------
module tb_axi_rd_slv_sram;
    import axi_pkg::*;

    localparam int IDW = 4;
    localparam int DW  = 256;
    localparam int AW  = 12;

    typedef struct {
        logic [IDW-1:0] id;
        logic [DW-1:0]  data;
        logic [1:0]     resp;
        logic           last;
        logic           chk_data;
    } exp_t;

    logic          aclk;
    logic          aresetn;
    logic          sram_cs;
    logic [AW-1:0] sram_addr;
    logic [DW-1:0] sram_rdata;
    logic          busy;

    logic [DW-1:0] mem [1 << AW];
    exp_t          exp_q[$];
    exp_t          e;

    int            total;
    int            bad;
    int unsigned   cyc;
    int unsigned   last_ar_cyc;
    int            beat_cnt;
    int            rr_mode;
    logic          stalled;
    logic [263:0]  held;

    axi_rd_slv_sram_if #(.IDW(IDW), .DW(DW)) axi ();

    axi_rd_slv_sram #(
        .AXI_IDW      (IDW),
        .AXI_DATA_WID (DW),
        .SRAM_AW      (AW),
        .OUTSTD_DEPTH (4)
    ) dut (
        .aclk         (aclk),
        .aresetn      (aresetn),
        .axi          (axi),
        .o_sram_cs    (sram_cs),
        .o_sram_addr  (sram_addr),
        .i_sram_rdata (sram_rdata),
        .o_busy       (busy)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    initial cyc = 0;
    always @(posedge aclk) cyc <= cyc + 1;

    // Synchronous single-port SRAM: data one cycle after the strobe.
    always @(posedge aclk) begin
        if (sram_cs) sram_rdata <= mem[sram_addr];
    end

    task automatic check_output(input string name, input logic [263:0] act, input logic [263:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    // Expected beats straight from the AXI rules: word address from the
    // bits above the 32-byte lane, incrementing modulo the SRAM depth
    // unless FIXED; error on WRAP/reserved, size != 5 or high address bits.
    task automatic push_expected(input logic [IDW-1:0] id, input logic [31:0] addr,
                                 input logic [3:0] len, input logic [2:0] size,
                                 input logic [1:0] burst);
        int   word;
        int   a;
        logic err;
        logic odd_burst;
        exp_t x;
        word      = int'(addr[16:5]);
        odd_burst = (burst == 2'b10) || (burst == 2'b11);
        err       = odd_burst || (size != 3'd5) || (addr[31:17] != 15'd0);
        for (int b = 0; b <= int'(len); b++) begin
            a          = (burst == 2'b00) ? word : (word + b) % 4096;
            x.id       = id;
            x.data     = mem[a];
            x.resp     = err ? 2'b10 : 2'b00;
            x.last     = (b == int'(len));
            x.chk_data = !odd_burst;
            exp_q.push_back(x);
        end
    endtask

    task automatic apply_stimulus(input logic [IDW-1:0] id, input logic [31:0] addr,
                                  input logic [3:0] len, input logic [2:0] size,
                                  input logic [1:0] burst);
        logic accepted;
        accepted = 1'b0;
        @(posedge aclk);
        #1;
        axi.arvalid = 1'b1;
        axi.arid    = id;
        axi.araddr  = addr;
        axi.arlen   = len;
        axi.arsize  = size;
        axi.arburst = burst;
        for (int k = 0; k < 400; k++) begin
            @(negedge aclk);
            if (axi.arready) begin
                accepted    = 1'b1;
                last_ar_cyc = cyc;
                break;
            end
        end
        if (!accepted) begin
            check_output("ar_timeout", 264'(1), 264'(0));
            axi.arvalid = 1'b0;
            return;
        end
        @(posedge aclk);
        push_expected(id, addr, len, size, burst);
        #1;
        axi.arvalid = 1'b0;
    endtask

    task automatic wait_drain(input int limit);
        for (int k = 0; k < limit; k++) begin
            @(negedge aclk);
            if (exp_q.size() == 0 && !busy) break;
        end
        check_output("drain", 264'({exp_q.size() != 0, busy}), 264'(0));
    endtask

    task automatic set_rready_mode(input int mode);
        rr_mode = mode;
        repeat (2) @(posedge aclk);
        #3;
    endtask

    // rready pattern: 0 = always 1, 1 = toggle, 2 = always 0, 3 = random.
    initial begin
        forever begin
            @(posedge aclk);
            #2;
            case (rr_mode)
                0:       axi.rready = 1'b1;
                1:       axi.rready = !axi.rready;
                2:       axi.rready = 1'b0;
                default: axi.rready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor: compare each R handshake with the scoreboard head and check
    // that a stalled beat is presented unchanged on the next cycle.
    always @(negedge aclk) begin
        if (!aresetn) begin
            stalled = 1'b0;
        end else begin
            if (stalled) begin
                check_output("r_hold", {axi.rvalid, axi.rid, axi.rresp, axi.rlast, axi.rdata}, held);
            end
            if (axi.rvalid && axi.rready) begin
                if (exp_q.size() == 0) begin
                    check_output("r_unexpected", 264'(1), 264'(0));
                end else begin
                    e = exp_q.pop_front();
                    check_output("r_id", 264'(axi.rid), 264'(e.id));
                    check_output("r_resp", 264'(axi.rresp), 264'(e.resp));
                    check_output("r_last", 264'(axi.rlast), 264'(e.last));
                    if (e.chk_data) check_output("r_data", 264'(axi.rdata), 264'(e.data));
                end
                beat_cnt++;
            end
            stalled = axi.rvalid && !axi.rready;
            held    = {1'b1, axi.rid, axi.rresp, axi.rlast, axi.rdata};
        end
    end

    initial begin
        total       = 0;
        bad         = 0;
        beat_cnt    = 0;
        stalled     = 1'b0;
        held        = '0;
        last_ar_cyc = 0;
        rr_mode     = 2;
        sram_rdata  = '0;
        aresetn     = 1'b0;
        axi.arvalid = 1'b0;
        axi.arid    = '0;
        axi.araddr  = '0;
        axi.arlen   = '0;
        axi.arsize  = '0;
        axi.arburst = '0;
        axi.rready  = 1'b0;
        for (int i = 0; i < (1 << AW); i++) begin
            for (int w = 0; w < DW / 32; w++) begin
                mem[i][w*32 +: 32] = $urandom;
            end
        end

        // Reset state
        #23;
        check_output("rst_r", {axi.rvalid, axi.rid, axi.rresp, axi.rlast, axi.rdata}, 264'(0));
        check_output("rst_cs_busy", 264'({sram_cs, busy}), 264'(0));
        @(negedge aclk);
        aresetn = 1'b1;
        @(negedge aclk);
        check_output("rst_arready", 264'(axi.arready), 264'(1));

        // 1: single beat, latency T+1 for cs and T+3 for rvalid
        set_rready_mode(0);
        apply_stimulus(4'd3, 32'h40, 4'd0, 3'd5, BURST_INCR);
        @(negedge aclk);
        check_output("t1_cs", 264'({sram_cs, sram_addr}), 264'({1'b1, 12'd2}));
        for (int k = 0; k < 10; k++) begin
            if (axi.rvalid) break;
            @(negedge aclk);
        end
        check_output("t1_latency", 264'(cyc), 264'(last_ar_cyc + 3));
        wait_drain(50);

        // 2: 16-beat INCR with rready toggling
        set_rready_mode(1);
        apply_stimulus(4'd1, 32'h0, 4'd15, 3'd5, BURST_INCR);
        wait_drain(200);

        // 3: five back-to-back ARs while R is stalled, then a gapless drain
        set_rready_mode(2);
        for (int i = 0; i < 5; i++) begin
            apply_stimulus(4'(i), 32'h1000 + 32'(i * 32'h80), 4'd3, 3'd5, BURST_INCR);
        end
        @(negedge aclk);
        check_output("t3_arready_full", 264'(axi.arready), 264'(0));
        rr_mode = 0;
        @(posedge aclk);
        #3;
        for (int k = 0; k < 20; k++) begin
            @(negedge aclk);
            check_output("t3_no_gap", 264'(axi.rvalid), 264'(1));
        end
        wait_drain(100);

        // 4: WRAP burst and narrow size both answer with SLVERR
        apply_stimulus(4'd9, 32'h300, 4'd3, 3'd5, BURST_WRAP);
        apply_stimulus(4'd10, 32'h320, 4'd0, 3'd2, BURST_INCR);
        wait_drain(100);

        // 5: word address wraps from the last SRAM word to word 0
        apply_stimulus(4'd5, 32'h1FFE0, 4'd1, 3'd5, BURST_INCR);
        wait_drain(100);

        // 6: reset during beat 5 of a 16-beat burst with two queued ARs
        beat_cnt = 0;
        apply_stimulus(4'd5, 32'h0, 4'd15, 3'd5, BURST_INCR);
        apply_stimulus(4'd6, 32'h200, 4'd3, 3'd5, BURST_INCR);
        apply_stimulus(4'd7, 32'h400, 4'd3, 3'd5, BURST_INCR);
        for (int k = 0; k < 100; k++) begin
            if (beat_cnt >= 4) break;
            @(negedge aclk);
        end
        check_output("t6_beats_before_rst", 264'(beat_cnt), 264'(4));
        @(posedge aclk);
        #1;
        aresetn = 1'b0;
        exp_q.delete();
        #1;
        check_output("t6_rst_r", {axi.rvalid, axi.rid, axi.rresp, axi.rlast, axi.rdata}, 264'(0));
        check_output("t6_rst_cs_busy", 264'({sram_cs, busy}), 264'(0));
        repeat (3) @(negedge aclk);
        aresetn = 1'b1;
        apply_stimulus(4'd2, 32'h60, 4'd0, 3'd5, BURST_INCR);
        wait_drain(100);
        check_output("t6_no_residual", 264'({axi.rvalid, busy}), 264'(0));

        // Randomized traffic with random back-pressure
        set_rready_mode(3);
        for (int n = 0; n < 40; n++) begin
            logic [31:0] addr;
            logic [1:0]  burst;
            logic [2:0]  size;
            int          r;
            r     = $urandom_range(0, 9);
            burst = (r < 6) ? BURST_INCR : (r < 8) ? BURST_FIXED : (r == 8) ? BURST_WRAP : 2'b11;
            size  = ($urandom_range(0, 9) == 0) ? 3'($urandom) : 3'd5;
            addr  = ($urandom_range(0, 19) == 0) ? 32'($urandom) : 32'($urandom_range(0, 32'h1FFFF));
            apply_stimulus(4'($urandom), addr, 4'($urandom_range(0, 15)), size, burst);
        end
        wait_drain(4000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
